cpl_checker: RTL and testbench

CPL_CHECKER -- requirements
Module: cpl_checker

---
 rtl/cpl_checker.sv | 205 ++++++++++++++++++++
 tb/tb_cpl_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpl_checker.sv
// cpl_checker
//   Checks PCIe completion TLPs arriving on a 64-bit AXI-stream receive port
//   against an expected kind (Cpl/CplD), tag, requester ID and payload DW.
//   Each completion produces one pulse the cycle after its last beat:
//   rx_good if everything matched, otherwise rx_bad.
//   Non-completion TLPs are consumed silently.
//
// Parameters
//   TCQ           clock-to-out delay used on registered assignments (sim only)
//   REQUESTER_ID  requester ID expected in completion DW2[31:16]
//
// Ports
//   user_clk, reset       clock, synchronous active-high reset
//   m_axis_rx_*           receive stream (DW0 in [31:0], DW1 in [63:32])
//   rx_type/rx_tag/rx_data expected completion fields, sampled live
//   rx_good / rx_bad      one-cycle result pulses
//
// Optional build macro CPL_CHECKER_DEBUG_EN adds:
//   err_code[3:0]   cause of the most recent rx_bad (1 type, 2 status,
//                   3 length, 4 truncated, 5 reqid, 6 tag, 7 data, 8 tkeep,
//                   9 overlength); lowest cause wins
//   bad_count[7:0]  number of rx_bad pulses, saturating at 8'hFF
module cpl_checker #(
    parameter int          TCQ          = 1,
    parameter logic [15:0] REQUESTER_ID = 16'h0000
) (
    input  logic        user_clk,
    input  logic        reset,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tvalid,
    input  logic        m_axis_rx_tlast,
    output logic        m_axis_rx_tready,
    input  logic        rx_type,
    input  logic [7:0]  rx_tag,
    input  logic [31:0] rx_data,
    output logic        rx_good,
    output logic        rx_bad
`ifdef CPL_CHECKER_DEBUG_EN
    ,
    output logic [3:0]  err_code,
    output logic [7:0]  bad_count
`endif
);

    typedef enum logic [1:0] {
        ST_HDR0   = 2'd0,
        ST_HDR1   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t r_state;
    logic   r_bad;      // sticky error flag for the TLP in flight
    logic   r_cpl;      // TLP in flight is a completion (drain must report)
    logic   r_good_q;
    logic   r_bad_q;

    logic       w_beat;
    logic       w_is_cpl;
    logic [1:0] w_exp_fmt;
    logic [3:0] w_h0_cause;
    logic [3:0] w_h1_cause;
    logic       w_h1_bad;

    // The receiver never back-pressures; only reset holds it off.
    assign m_axis_rx_tready = ~reset;
    assign w_beat           = m_axis_rx_tvalid & m_axis_rx_tready;

    // Completion: type 01010 with a 3DW header format (no data / with data).
    assign w_is_cpl  = (m_axis_rx_tdata[28:24] == 5'b01010) &&
                       ((m_axis_rx_tdata[30:29] == 2'b00) ||
                        (m_axis_rx_tdata[30:29] == 2'b10));
    assign w_exp_fmt = rx_type ? 2'b10 : 2'b00;

    // Causes are evaluated highest-number first so the lowest one wins.
    always_comb begin
        w_h0_cause = 4'd0;
        if (m_axis_rx_tlast)                          w_h0_cause = 4'd4;
        if (rx_type && m_axis_rx_tdata[9:0] != 10'd1) w_h0_cause = 4'd3;
        if (m_axis_rx_tdata[47:45] != 3'b000)         w_h0_cause = 4'd2;
        if (m_axis_rx_tdata[30:29] != w_exp_fmt)      w_h0_cause = 4'd1;
    end

    // Beat 1 without tlast means the TLP is longer than a 1-DW completion.
    always_comb begin
        w_h1_cause = 4'd0;
        if (!m_axis_rx_tlast)                                 w_h1_cause = 4'd9;
        if (rx_type  && m_axis_rx_tkeep != 8'hFF)             w_h1_cause = 4'd8;
        if (!rx_type && m_axis_rx_tkeep != 8'h0F)             w_h1_cause = 4'd8;
        if (rx_type  && m_axis_rx_tdata[63:32] != rx_data)    w_h1_cause = 4'd7;
        if (m_axis_rx_tdata[15:8]  != rx_tag)                 w_h1_cause = 4'd6;
        if (m_axis_rx_tdata[31:16] != REQUESTER_ID)           w_h1_cause = 4'd5;
    end

    assign w_h1_bad = r_bad | (w_h1_cause != 4'd0);

`ifdef CPL_CHECKER_DEBUG_EN
    logic [3:0] r_cause;
    logic [3:0] r_err_code;
    logic [7:0] r_bad_count;
    logic [3:0] w_h1_fin_cause;
    logic [7:0] w_cnt_inc;

    assign w_h1_fin_cause = (r_cause != 4'd0) ? r_cause : w_h1_cause;
    assign w_cnt_inc      = (r_bad_count == 8'hFF) ? r_bad_count : r_bad_count + 8'd1;
    assign err_code       = r_err_code;
    assign bad_count      = r_bad_count;
`endif

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_state  <= #TCQ ST_HDR0;
            r_bad    <= #TCQ 1'b0;
            r_cpl    <= #TCQ 1'b0;
            r_good_q <= #TCQ 1'b0;
            r_bad_q  <= #TCQ 1'b0;
`ifdef CPL_CHECKER_DEBUG_EN
            r_cause     <= #TCQ 4'd0;
            r_err_code  <= #TCQ 4'd0;
            r_bad_count <= #TCQ 8'd0;
`endif
        end else begin
            r_good_q <= #TCQ 1'b0;
            r_bad_q  <= #TCQ 1'b0;
            case (r_state)
                // The report cycle also accepts beat 0 of the next TLP.
                ST_HDR0, ST_REPORT: begin
                    if (w_beat) begin
                        if (w_is_cpl) begin
                            r_cpl <= #TCQ 1'b1;
                            r_bad <= #TCQ (w_h0_cause != 4'd0);
`ifdef CPL_CHECKER_DEBUG_EN
                            r_cause <= #TCQ w_h0_cause;
`endif
                            if (m_axis_rx_tlast) begin
                                // Truncated completion: always bad.
                                r_state <= #TCQ ST_REPORT;
                                r_bad_q <= #TCQ 1'b1;
`ifdef CPL_CHECKER_DEBUG_EN
                                r_err_code  <= #TCQ w_h0_cause;
                                r_bad_count <= #TCQ w_cnt_inc;
`endif
                            end else begin
                                r_state <= #TCQ ST_HDR1;
                            end
                        end else begin
                            r_cpl   <= #TCQ 1'b0;
                            r_bad   <= #TCQ 1'b0;
`ifdef CPL_CHECKER_DEBUG_EN
                            r_cause <= #TCQ 4'd0;
`endif
                            r_state <= #TCQ m_axis_rx_tlast ? ST_HDR0 : ST_DRAIN;
                        end
                    end else begin
                        r_state <= #TCQ ST_HDR0;
                    end
                end
                ST_HDR1: begin
                    if (w_beat) begin
                        r_bad <= #TCQ w_h1_bad;
`ifdef CPL_CHECKER_DEBUG_EN
                        r_cause <= #TCQ w_h1_fin_cause;
`endif
                        if (m_axis_rx_tlast) begin
                            r_state  <= #TCQ ST_REPORT;
                            r_good_q <= #TCQ ~w_h1_bad;
                            r_bad_q  <= #TCQ w_h1_bad;
`ifdef CPL_CHECKER_DEBUG_EN
                            if (w_h1_bad) begin
                                r_err_code  <= #TCQ w_h1_fin_cause;
                                r_bad_count <= #TCQ w_cnt_inc;
                            end
`endif
                        end else begin
                            r_state <= #TCQ ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_beat && m_axis_rx_tlast) begin
                        if (r_cpl) begin
                            r_state  <= #TCQ ST_REPORT;
                            r_good_q <= #TCQ ~r_bad;
                            r_bad_q  <= #TCQ r_bad;
`ifdef CPL_CHECKER_DEBUG_EN
                            if (r_bad) begin
                                r_err_code  <= #TCQ r_cause;
                                r_bad_count <= #TCQ w_cnt_inc;
                            end
`endif
                        end else begin
                            r_state <= #TCQ ST_HDR0;
                        end
                    end
                end
                default: r_state <= #TCQ ST_HDR0;
            endcase
        end
    end

    assign rx_good = r_good_q;
    assign rx_bad  = r_bad_q;

endmodule

// File: tb/tb_cpl_checker.sv
// Directed-vector bench for cpl_checker. The driver pushes the expected
// pulse (kind, cycle, debug cause) into a queue; a negedge monitor pops and
// compares whenever the DUT pulses, and flags pulses that never arrive.
module tb_cpl_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        rx_type = 1'b0;
    logic [7:0]  rx_tag = '0;
    logic [31:0] rx_data = '0;
    logic        rx_good, rx_bad;
`ifdef CPL_CHECKER_DEBUG_EN
    logic [3:0]  err_code;
    logic [7:0]  bad_count;
`endif

    cpl_checker #(.TCQ(1), .REQUESTER_ID(16'h0000)) dut (
        .user_clk         (clk),
        .reset            (rst),
        .m_axis_rx_tdata  (tdata),
        .m_axis_rx_tkeep  (tkeep),
        .m_axis_rx_tvalid (tvalid),
        .m_axis_rx_tlast  (tlast),
        .m_axis_rx_tready (tready),
        .rx_type          (rx_type),
        .rx_tag           (rx_tag),
        .rx_data          (rx_data),
        .rx_good          (rx_good),
        .rx_bad           (rx_bad)
`ifdef CPL_CHECKER_DEBUG_EN
        ,
        .err_code         (err_code),
        .bad_count        (bad_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 1 good, 2 bad
        int         cyc;
        logic [3:0] ec;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // One accepted beat; exp: 0 none, 1 good pulse, 2 bad pulse.
    task automatic beat(input logic [63:0] d, input logic [7:0] k,
                        input logic last, input int exp, input logic [3:0] ec);
        exp_t e;
        @(posedge clk); #2;
        tdata = d; tkeep = k; tvalid = 1'b1; tlast = last;
        if (exp != 0) begin
            if (exp == 2) exp_cnt++;
            e.kind = exp; e.cyc = cyc + 1; e.ec = ec; e.cnt = exp_cnt;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            tvalid = 1'b0; tlast = 1'b0;
        end
    endtask

    task automatic good_cpld();
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0000_0500}, 8'hFF, 1'b1, 1, 4'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (tready !== ~rst) begin
                n_err++;
                $display("FAIL tready: got %b want %b at cyc %0d", tready, ~rst, cyc);
            end
            if (rx_good === 1'b1 || rx_bad === 1'b1) begin
                n_cmp++;
                if (rst || q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: good=%b bad=%b at cyc %0d", rx_good, rx_bad, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ((e.kind == 1 && !(rx_good === 1'b1 && rx_bad === 1'b0)) ||
                        (e.kind == 2 && !(rx_bad === 1'b1 && rx_good === 1'b0)) ||
                        e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL pulse: got good=%b bad=%b cyc %0d want kind %0d cyc %0d",
                                 rx_good, rx_bad, cyc, e.kind, e.cyc);
                    end
`ifdef CPL_CHECKER_DEBUG_EN
                    if (e.kind == 2) begin
                        n_cmp++;
                        if (err_code !== e.ec || bad_count !== e.cnt[7:0]) begin
                            n_err++;
                            $display("FAIL debug: err_code %0d bad_count %0d want %0d %0d",
                                     err_code, bad_count, e.ec, e.cnt);
                        end
                    end
`endif
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                exp_t e;
                e = q.pop_front();
                n_cmp++; n_err++;
                $display("FAIL missing_pulse: kind %0d expected at cyc %0d", e.kind, e.cyc);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (tready !== 1'b0 || rx_good !== 1'b0 || rx_bad !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: tready %b good %b bad %b want 0 0 0", tready, rx_good, rx_bad);
        end
`ifdef CPL_CHECKER_DEBUG_EN
        n_cmp++;
        if (err_code !== 4'd0 || bad_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_debug: err_code %0d bad_count %0d want 0 0", err_code, bad_count);
        end
`endif
        mon_en = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        idle(2);

        // Good CplD
        rx_type = 1'b1; rx_tag = 8'h05; rx_data = 32'h1234_5678;
        good_cpld(); idle(2);
        // Data mismatch
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5679, 32'h0000_0500}, 8'hFF, 1'b1, 2, 4'd7); idle(2);
        // Good Cpl, then bad status
        rx_type = 1'b0; rx_tag = 8'h06;
        beat({32'h0000_0000, 32'h0A00_0000}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0600}, 8'h0F, 1'b1, 1, 4'd0); idle(2);
        beat({32'h0000_2000, 32'h0A00_0000}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0600}, 8'h0F, 1'b1, 2, 4'd2); idle(2);
        // MemWr (no pulse) immediately followed by a good CplD
        rx_type = 1'b1; rx_tag = 8'h05;
        beat({32'h0000_0000, 32'h4000_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'hDEAD_BEEF, 32'h1000_0000}, 8'hFF, 1'b1, 0, 4'd0);
        good_cpld(); idle(2);
        // Length 2, three beats: one bad pulse after the third beat
        beat({32'h0000_0000, 32'h4A00_0002}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0000_0500}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0000}, 8'hFF, 1'b1, 2, 4'd3); idle(2);
        // Reset mid-TLP: no pulse, next TLP checked normally
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        @(posedge clk); #2; tvalid = 1'b0; tlast = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (tready !== 1'b0) begin
            n_err++;
            $display("FAIL tready_in_reset: got %b want 0", tready);
        end
        @(posedge clk); #2; rst = 1'b0;
        good_cpld(); idle(2);
        // Format mismatch (Cpl header while CplD expected)
        beat({32'h0000_0000, 32'h0A00_0000}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0500}, 8'h0F, 1'b1, 2, 4'd1); idle(2);
        // tlast on beat 0
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b1, 2, 4'd4); idle(2);
        // Requester ID, tag, tkeep mismatches
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0001_0500}, 8'hFF, 1'b1, 2, 4'd5); idle(1);
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0000_0700}, 8'hFF, 1'b1, 2, 4'd6); idle(1);
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0000_0500}, 8'h0F, 1'b1, 2, 4'd8); idle(1);
        // Overlength: length 1 but three beats
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0000_0500}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0000}, 8'hFF, 1'b1, 2, 4'd9); idle(2);
        // Idle gap between header beats must not disturb the check
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        idle(3);
        beat({32'h1234_5678, 32'h0000_0500}, 8'hFF, 1'b1, 1, 4'd0); idle(2);
        // Non-completions: single beat and multi-beat drain
        beat({32'h0000_0000, 32'h0000_0001}, 8'hFF, 1'b1, 0, 4'd0);
        beat({32'h0000_0000, 32'h4000_0002}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0000}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h0000_0000, 32'h0000_0000}, 8'hFF, 1'b1, 0, 4'd0); idle(2);
        // Back-to-back completions: beat 0 consumed in the report cycle
        good_cpld();
        good_cpld();
        beat({32'h0000_0000, 32'h4A00_0001}, 8'hFF, 1'b0, 0, 4'd0);
        beat({32'h1234_5678, 32'h0000_0600}, 8'hFF, 1'b1, 2, 4'd6);
        idle(6);

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations: %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
